alu_wb_buffer: RTL and testbench

- Writeback buffer directly downstream of the 64-bit ALU.
- Captures each ALU result, its Zero flag and the destination register index into a small in-order FIFO.
- Presents entries to the register-file write port using a valid/ready handshake.
- Decouples ALU issue from register-file write-port stalls.

---
 rtl/alu_wb_buffer.sv | 80 ++++++++
 tb/tb_alu_wb_buffer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_buffer.sv
// In-order writeback FIFO between the ALU and the register-file write port.
// Captures {result, zero, rd}; rd == 0 pushes are accepted but never stored.
module alu_wb_buffer #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_result,
    input  logic                     in_zero,
    input  logic [RD_W-1:0]          in_rd,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [DATA_W-1:0]        wb_data,
    output logic [RD_W-1:0]          wb_rd,
    output logic                     wb_zero,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     last_zero
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              zero;
        logic [RD_W-1:0]   rd;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             store;
    logic             pop;

    // Full buffer still accepts when the head drains in the same cycle.
    assign in_ready = (count < CNT_W'(DEPTH)) || wb_ready;
    assign wb_valid = (count != '0);
    assign store    = in_valid && in_ready && (in_rd != '0);
    assign pop      = wb_valid && wb_ready;

    assign wb_data  = mem[rd_ptr].data;
    assign wb_rd    = mem[rd_ptr].rd;
    assign wb_zero  = mem[rd_ptr].zero;

    // Storage array; contents are only meaningful below count.
    always_ff @(posedge clk) begin
        if (store) begin
            mem[wr_ptr] <= '{data: in_result, zero: in_zero, rd: in_rd};
        end
    end

    // Pointers, occupancy and last popped zero flag; flush overrides traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_zero <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                last_zero <= mem[rd_ptr].zero;
            end
            count <= count + CNT_W'(store) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed bench for alu_wb_buffer: queue-based reference model compared every
// cycle, plus literal expectations per scenario.
module tb_alu_wb_buffer;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned RD_W   = 5;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_zero;
    logic [RD_W-1:0]   in_rd;
    logic              wb_valid;
    logic              wb_ready;
    logic [DATA_W-1:0] wb_data;
    logic [RD_W-1:0]   wb_rd;
    logic              wb_zero;
    logic [2:0]        count;
    logic              last_zero;

    int n_cmp = 0;
    int n_bad = 0;

    alu_wb_buffer #(.DATA_W(DATA_W), .RD_W(RD_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
        .in_zero(in_zero), .in_rd(in_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_zero(wb_zero), .count(count), .last_zero(last_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [4:0]  rd;
        logic        zero;
    } ent_t;

    ent_t q[$];
    ent_t popped[$];
    logic m_last_zero = 1'b0;
    bit   m_rdy;
    bit   m_pop;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: an in-order queue updated by the handshake rules.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_last_zero = 1'b0;
        end else if (flush) begin
            q.delete();
        end else begin
            m_rdy = (q.size() < DEPTH) || wb_ready;
            m_pop = (q.size() != 0) && wb_ready;
            if (m_pop) begin
                m_last_zero = q[0].zero;
                popped.push_back(q[0]);
                void'(q.pop_front());
            end
            if (in_valid && m_rdy && in_rd != 5'd0)
                q.push_back('{data: in_result, rd: in_rd, zero: in_zero});
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_count", 64'(count), 64'(q.size()));
        chk("m_wb_valid", 64'(wb_valid), 64'(q.size() != 0));
        chk("m_in_ready", 64'(in_ready), 64'((q.size() < DEPTH) || wb_ready));
        chk("m_last_zero", 64'(last_zero), 64'(m_last_zero));
        if (q.size() != 0) begin
            chk("m_wb_data", wb_data, q[0].data);
            chk("m_wb_rd", 64'(wb_rd), 64'(q[0].rd));
            chk("m_wb_zero", 64'(wb_zero), 64'(q[0].zero));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic z, input logic [4:0] r);
        in_valid  = v;
        in_result = d;
        in_zero   = z;
        in_rd     = r;
    endtask

    task automatic fill_10_13();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'(10 + i), 1'b0, 5'(1 + i));
            step();
        end
        drive(1'b0, 64'd0, 1'b0, 5'd0);
    endtask

    task automatic chk_popped(input string name, input int idx, input logic [63:0] d, input logic [4:0] r);
        if (idx < popped.size()) begin
            chk({name, "_data"}, popped[idx].data, d);
            chk({name, "_rd"}, 64'(popped[idx].rd), 64'(r));
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        flush    = 1'b0;
        wb_ready = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_last_zero", 64'(last_zero), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        step();

        // Single push, one-cycle latency, then pop.
        drive(1'b1, 64'h5, 1'b0, 5'd3);
        step();
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        chk("t1_wb_valid", 64'(wb_valid), 64'd1);
        chk("t1_wb_data", wb_data, 64'd5);
        chk("t1_wb_rd", 64'(wb_rd), 64'd3);
        chk("t1_count", 64'(count), 64'd1);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("t1_count_after", 64'(count), 64'd0);
        chk("t1_wb_valid_after", 64'(wb_valid), 64'd0);
        chk("t1_last_zero", 64'(last_zero), 64'd0);

        // Fill to full, then drain in order.
        fill_10_13();
        chk("t2_count_full", 64'(count), 64'd4);
        chk("t2_in_ready_full", 64'(in_ready), 64'd0);
        popped.delete();
        wb_ready = 1'b1;
        repeat (4) step();
        wb_ready = 1'b0;
        chk("t2_npop", 64'(popped.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk_popped("t2_pop", i, 64'(10 + i), 5'(1 + i));

        // Full-rate streaming through a full buffer.
        fill_10_13();
        popped.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 64'(20 + i), 1'b0, 5'(8 + i));
            wb_ready = 1'b1;
            step();
            chk("t3_count_stream", 64'(count), 64'd4);
        end
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        repeat (4) step();
        wb_ready = 1'b0;
        chk("t3_npop", 64'(popped.size()), 64'd12);
        for (int i = 0; i < 4; i++) chk_popped("t3_pop_a", i, 64'(10 + i), 5'(1 + i));
        for (int i = 0; i < 8; i++) chk_popped("t3_pop_b", 4 + i, 64'(20 + i), 5'(8 + i));

        // rd == 0 push is accepted but dropped.
        popped.delete();
        drive(1'b1, 64'd7, 1'b0, 5'd5);
        step();
        chk("t4_count_a", 64'(count), 64'd1);
        drive(1'b1, 64'd99, 1'b0, 5'd0);
        step();
        chk("t4_count_x0", 64'(count), 64'd1);
        drive(1'b1, 64'd8, 1'b0, 5'd6);
        step();
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        chk("t4_count_peak", 64'(count), 64'd2);
        wb_ready = 1'b1;
        repeat (2) step();
        wb_ready = 1'b0;
        chk("t4_npop", 64'(popped.size()), 64'd2);
        chk_popped("t4_pop", 0, 64'd7, 5'd5);
        chk_popped("t4_pop", 1, 64'd8, 5'd6);

        // Flush wins over same-cycle push and pop.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'(30 + i), 1'b0, 5'(1 + i));
            step();
        end
        popped.delete();
        drive(1'b1, 64'd40, 1'b0, 5'd4);
        wb_ready = 1'b1;
        flush    = 1'b1;
        #1;
        chk("t5_in_ready_flush", 64'(in_ready), 64'd1);
        step();
        flush    = 1'b0;
        wb_ready = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        chk("t5_count", 64'(count), 64'd0);
        chk("t5_wb_valid", 64'(wb_valid), 64'd0);
        chk("t5_npop", 64'(popped.size()), 64'd0);
        drive(1'b1, 64'd1, 1'b0, 5'd1);
        step();
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        chk("t5_post_valid", 64'(wb_valid), 64'd1);
        chk("t5_post_data", wb_data, 64'd1);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;

        // Zero flag capture, then asynchronous reset mid-operation.
        drive(1'b1, 64'd0, 1'b1, 5'd7);
        step();
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        wb_ready = 1'b1;
        step();
        wb_ready = 1'b0;
        chk("t6_last_zero", 64'(last_zero), 64'd1);
        drive(1'b1, 64'd50, 1'b0, 5'd2);
        step();
        drive(1'b1, 64'd51, 1'b0, 5'd3);
        step();
        drive(1'b0, 64'd0, 1'b0, 5'd0);
        chk("t6_count_pre", 64'(count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_count", 64'(count), 64'd0);
        chk("t6_async_wb_valid", 64'(wb_valid), 64'd0);
        chk("t6_async_last_zero", 64'(last_zero), 64'd0);
        step();
        rst_n = 1'b1;
        repeat (2) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
